pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Pipeline control sequencer that consumes the hazard unit's requests and drives the per-stage pipeline-register controls for the 5-stage core (fetch, fetchTOdecode, decodeTOexecute, executeTOmem, memTOwrite). It turns the load-use interlock, taken-branch redirect and data-memory busy into register enables, bubble insertion and flushes, and keeps saturating stall and flush event counters. It sits beside the hazard unit in the core top level.

## Interface
- FLUSH_CYCLES, 1: cycles that fetchTOdecode and decodeTOexecute are flushed per taken branch; legal range 1–4.
- CNT_W, 16: width of each event counter.
- clk  in  1  core clock; all state updates on its rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- itr_i  in  1  load-use interlock request from the hazard unit.
- branch_taken_i  in  1  taken branch or jump resolved in execute.
- mem_busy_i  in  1  data memory not ready; the whole pipe must freeze.
- cnt_clr_i  in  1  synchronous clear of both counters.
- pc_en_o  out  1  PC/fetch advance enable.
- fd_en_o, de_en_o, em_en_o, mw_en_o  out  1 each  pipeline-register load enables.
- de_bubble_o  out  1  decodeTOexecute loads a NOP this cycle.
- fd_flush_o, de_flush_o  out  1 each  the register loads a NOP; applied only when its enable is 1.
- state_o  out  2  current state: RUN=0, LSTALL=1, FLUSH=2, FREEZE=3.
- stall_cnt_o  out  CNT_W  stall-cycle count.
- flush_cnt_o  out  CNT_W  taken-branch event count.

## Operation
- **States.** RUN, LSTALL, FLUSH, FREEZE. `fcnt` is a 2-bit flush-cycle counter.
- **Outputs.** All outputs are combinational from state, `fcnt` and the current-cycle inputs, so a stall takes effect in the cycle the request is raised.
- **Priority per cycle.** mem_busy_i > branch_taken_i > itr_i.
- **mem_busy_i=1, any state.**
  - All enables 0; de_bubble and flushes 0.
  - Go to FREEZE. The pre-freeze state and `fcnt` are saved in a return register.
  - branch_taken_i and itr_i are ignored. Their sources are frozen, so they are re-presented after the freeze.
- **FREEZE with mem_busy_i=0.** Return to the saved state with `fcnt` unchanged, then evaluate that state's rules in the same cycle.
- **RUN, branch_taken_i=1.**
  - All enables 1; fd_flush_o=de_flush_o=1.
  - flush_cnt increments.
  - If FLUSH_CYCLES>1: go to FLUSH with `fcnt`=FLUSH_CYCLES-1. Otherwise stay in RUN.
- **RUN, itr_i=1, no branch.**
  - pc_en=fd_en=0; de_en=1 with de_bubble_o=1; em_en=mw_en=1.
  - Go to LSTALL.
- **RUN, no request.** All enables 1; go to RUN.
- **LSTALL.**
  - Exactly one bubble per load. itr_i is masked for this cycle.
  - All enables 1; go to RUN.
  - A branch_taken_i here is handled exactly as in RUN.
- **FLUSH.**
  - All enables 1; fd_flush=de_flush=1.
  - `fcnt` decrements. Go to RUN when `fcnt` reaches 1→0.
  - A new branch_taken_i reloads `fcnt`=FLUSH_CYCLES-1 and increments flush_cnt.
  - itr_i is ignored: the decode instruction is wrong-path.
- **stall_cnt.** Increments in every cycle where pc_en_o=0 (load bubble or freeze).
- **Counter rules.**
  - Both counters saturate at 2^CNT_W-1; there is no wrap.
  - cnt_clr_i takes precedence over an increment in the same cycle: the result is 0.

## Timing
- Request-to-control latency is 0 cycles (combinational). State and counters update on the rising edge.
- **While n_reset=0:**
  - state=RUN, `fcnt`=0, counters 0.
  - All enables, de_bubble and flush outputs are forced to 0.
  - state_o=0.
- **Reset release.** The first rising edge after n_reset deasserts with no requests has all enables 1.
- **Reset mid-operation** (LSTALL, FLUSH or FREEZE): immediately abandons the sequence. No bubble or flush completes after reset.
- **Load-use.** One stall cycle per itr_i assertion in RUN. Continuous itr_i yields stall, run, stall, run (alternating).
- **Taken branch.** Flushes last exactly FLUSH_CYCLES cycles unless extended by freeze (paused) or a new branch (restarted).
- **Counter values.** Visible one cycle after the event.

## Test plan
- **Reset.** Hold n_reset=0 for 3 cycles with itr_i=1 → all enables 0, counters 0, state_o=0. Release → RUN with all enables 1.
- **Load-use.** itr_i=1 for 1 cycle in RUN → same cycle: pc_en=fd_en=0, de_bubble=1. Next cycle: state_o=1, enables 1. stall_cnt=1. Held itr_i for 4 cycles → 2 stalls, stall_cnt=2.
- **Branch with FLUSH_CYCLES=3.** branch_taken_i for 1 cycle → fd_flush=de_flush=1 for 3 consecutive cycles, flush_cnt=1, back to RUN.
- **Simultaneous requests.** branch_taken_i and itr_i in the same cycle → flush only, no bubble. mem_busy_i high too → all enables 0, state FREEZE, flush_cnt unchanged.
- **Freeze mid-flush.** FLUSH_CYCLES=2; mem_busy_i for 5 cycles during the second flush cycle → 5 frozen cycles, stall_cnt+=5, then the remaining flush cycle, then RUN.
- **Saturation and clear.** CNT_W=4; 20 freeze cycles → stall_cnt=15. cnt_clr_i together with a stall → next value 0.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl_if
//  Description : Hazard-request / pipeline-control bundle of pipe_stall_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stall_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             itr_i;
   logic             branch_taken_i;
   logic             mem_busy_i;
   logic             cnt_clr_i;
   logic             pc_en_o;
   logic             fd_en_o;
   logic             de_en_o;
   logic             em_en_o;
   logic             mw_en_o;
   logic             de_bubble_o;
   logic             fd_flush_o;
   logic             de_flush_o;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport master (
      output itr_i, branch_taken_i, mem_busy_i, cnt_clr_i,
      input  pc_en_o, fd_en_o, de_en_o, em_en_o, mw_en_o,
      input  de_bubble_o, fd_flush_o, de_flush_o, state_o,
      input  stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  itr_i, branch_taken_i, mem_busy_i, cnt_clr_i,
      output pc_en_o, fd_en_o, de_en_o, em_en_o, mw_en_o,
      output de_bubble_o, fd_flush_o, de_flush_o, state_o,
      output stall_cnt_o, flush_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl
//  Description : Turns hazard requests into per-stage enables, bubbles and
//                flushes for the 5-stage core; counts stall and flush events.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  wire logic         clk,
   input  wire logic         n_reset,
   pipe_stall_ctrl_if.slave  bus
);

   localparam logic [1:0] S_RUN    = 2'd0;
   localparam logic [1:0] S_LSTALL = 2'd1;
   localparam logic [1:0] S_FLUSH  = 2'd2;
   localparam logic [1:0] S_FREEZE = 2'd3;

   localparam logic [1:0]       c_FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_CNT_MAX      = '1;

   logic [1:0]       r_state;
   logic [1:0]       r_ret_state;
   logic [1:0]       r_fcnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic [1:0]       w_state_nxt;
   logic [1:0]       w_ret_nxt;
   logic [1:0]       w_fcnt_nxt;
   logic [1:0]       w_eff_state;
   logic             w_flush_evt;
   logic             w_stall_evt;

   logic             w_pc_en;
   logic             w_fd_en;
   logic             w_de_en;
   logic             w_em_en;
   logic             w_mw_en;
   logic             w_de_bubble;
   logic             w_fd_flush;
   logic             w_de_flush;

   // Leaving FREEZE resumes the saved state within the same cycle.
   assign w_eff_state = (r_state == S_FREEZE) ? r_ret_state : r_state;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state     <= S_RUN;
         r_ret_state <= S_RUN;
         r_fcnt      <= 2'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_ret_state <= w_ret_nxt;
         r_fcnt      <= w_fcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ret_nxt   = r_ret_state;
      w_fcnt_nxt  = r_fcnt;
      w_flush_evt = 1'b0;
      if (bus.mem_busy_i) begin
         w_state_nxt = S_FREEZE;
         w_ret_nxt   = w_eff_state;
      end else if (bus.branch_taken_i) begin
         w_flush_evt = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            w_state_nxt = S_FLUSH;
            w_fcnt_nxt  = c_FLUSH_RELOAD;
         end else begin
            w_state_nxt = S_RUN;
         end
      end else begin
         case (w_eff_state)
            S_FLUSH: begin
               w_fcnt_nxt  = r_fcnt - 2'd1;
               w_state_nxt = (r_fcnt == 2'd1) ? S_RUN : S_FLUSH;
            end
            S_RUN:   w_state_nxt = bus.itr_i ? S_LSTALL : S_RUN;
            default: w_state_nxt = S_RUN;
         endcase
      end
   end

   always_comb begin
      w_pc_en     = 1'b0;
      w_fd_en     = 1'b0;
      w_de_en     = 1'b0;
      w_em_en     = 1'b0;
      w_mw_en     = 1'b0;
      w_de_bubble = 1'b0;
      w_fd_flush  = 1'b0;
      w_de_flush  = 1'b0;
      if (n_reset && !bus.mem_busy_i) begin
         w_pc_en = 1'b1;
         w_fd_en = 1'b1;
         w_de_en = 1'b1;
         w_em_en = 1'b1;
         w_mw_en = 1'b1;
         if (bus.branch_taken_i || (w_eff_state == S_FLUSH)) begin
            w_fd_flush = 1'b1;
            w_de_flush = 1'b1;
         end else if ((w_eff_state == S_RUN) && bus.itr_i) begin
            w_pc_en     = 1'b0;
            w_fd_en     = 1'b0;
            w_de_bubble = 1'b1;
         end
      end
   end

   assign w_stall_evt = n_reset && !w_pc_en;

   // Clear wins over a same-cycle increment; both counters stick at max.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (bus.cnt_clr_i) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_evt && (r_stall_cnt != c_CNT_MAX))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush_evt && (r_flush_cnt != c_CNT_MAX))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign bus.pc_en_o     = w_pc_en;
   assign bus.fd_en_o     = w_fd_en;
   assign bus.de_en_o     = w_de_en;
   assign bus.em_en_o     = w_em_en;
   assign bus.mw_en_o     = w_mw_en;
   assign bus.de_bubble_o = w_de_bubble;
   assign bus.fd_flush_o  = w_fd_flush;
   assign bus.de_flush_o  = w_de_flush;
   assign bus.state_o     = r_state;
   assign bus.stall_cnt_o = r_stall_cnt;
   assign bus.flush_cnt_o = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stall_ctrl
//  Description : Directed bench for pipe_stall_ctrl (FLUSH_CYCLES=3, CNT_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

   localparam int FC = 3;
   localparam int CW = 4;

   // ctrl = {pc, fd, de, em, mw, bubble, fd_flush, de_flush}
   localparam logic [7:0] C_ZERO  = 8'h00;
   localparam logic [7:0] C_RUN   = 8'hF8;
   localparam logic [7:0] C_STALL = 8'h3C;
   localparam logic [7:0] C_FLUSH = 8'hFB;

   localparam logic [1:0] S_RUN    = 2'd0;
   localparam logic [1:0] S_LSTALL = 2'd1;
   localparam logic [1:0] S_FLUSH  = 2'd2;
   localparam logic [1:0] S_FREEZE = 2'd3;

   typedef struct packed {
      logic [7:0]    ctrl;
      logic [1:0]    st;
      logic [CW-1:0] stall;
      logic [CW-1:0] flush;
   } exp_t;

   logic clk;
   logic n_reset;
   int   vectors;
   int   miscompares;
   exp_t sb[$];
   logic [7:0] obs_ctrl;

   pipe_stall_ctrl_if #(.CNT_W(CW)) bus ();

   pipe_stall_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (bus.slave)
   );

   assign obs_ctrl = {bus.pc_en_o, bus.fd_en_o, bus.de_en_o, bus.em_en_o,
                      bus.mw_en_o, bus.de_bubble_o, bus.fd_flush_o, bus.de_flush_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic rst, input logic itr, input logic br,
                       input logic busy, input logic clr,
                       input logic [7:0] ectrl, input logic [1:0] est,
                       input int estall, input int eflush, input string tag);
      exp_t e;
      @(negedge clk);
      n_reset            = rst;
      bus.itr_i          = itr;
      bus.branch_taken_i = br;
      bus.mem_busy_i     = busy;
      bus.cnt_clr_i      = clr;
      e.ctrl  = ectrl;
      e.st    = est;
      e.stall = CW'(estall);
      e.flush = CW'(eflush);
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      vectors++;
      assert (obs_ctrl === e.ctrl) else begin
         miscompares++;
         $error("FAIL %s ctrl observed=%h expected=%h", tag, obs_ctrl, e.ctrl);
      end
      vectors++;
      assert (bus.state_o === e.st) else begin
         miscompares++;
         $error("FAIL %s state observed=%0d expected=%0d", tag, bus.state_o, e.st);
      end
      vectors++;
      assert (bus.stall_cnt_o === e.stall) else begin
         miscompares++;
         $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, bus.stall_cnt_o, e.stall);
      end
      vectors++;
      assert (bus.flush_cnt_o === e.flush) else begin
         miscompares++;
         $error("FAIL %s flush_cnt observed=%0d expected=%0d", tag, bus.flush_cnt_o, e.flush);
      end
   endtask

   initial begin
      vectors            = 0;
      miscompares        = 0;
      n_reset            = 1'b0;
      bus.itr_i          = 1'b1;
      bus.branch_taken_i = 1'b0;
      bus.mem_busy_i     = 1'b0;
      bus.cnt_clr_i      = 1'b0;

      // reset held with a pending interlock
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_ZERO, S_RUN, 0, 0, "reset");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, S_RUN, 0, 0, "release");

      // single load-use
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_STALL, S_RUN,    0, 0, "lu_req");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   S_LSTALL, 1, 0, "lu_after");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   S_RUN,    1, 0, "lu_idle");

      // held interlock alternates stall / run
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_STALL, S_RUN,    1, 0, "lu_held0");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN,   S_LSTALL, 2, 0, "lu_held1");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_STALL, S_RUN,    2, 0, "lu_held2");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN,   S_LSTALL, 3, 0, "lu_held3");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   S_RUN,    3, 0, "lu_done");

      // taken branch: three flush cycles
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_FLUSH, S_RUN,   3, 0, "br_0");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_FLUSH, S_FLUSH, 3, 1, "br_1");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_FLUSH, S_FLUSH, 3, 1, "br_2");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   S_RUN,   3, 1, "br_done");

      // branch + interlock together, then all three with busy
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, C_FLUSH, S_RUN,    3, 1, "sim_br_itr");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_FLUSH, S_FLUSH,  3, 2, "sim_fl1");
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, C_ZERO,  S_FLUSH,  3, 2, "sim_busy");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_FLUSH, S_FREEZE, 4, 2, "sim_resume");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   S_RUN,    4, 2, "sim_done");

      // freeze in the second flush cycle pauses the sequence
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_FLUSH, S_RUN, 4, 2, "frz_br");
      for (int i = 0; i < 5; i++)
         step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, C_ZERO, (i == 0) ? S_FLUSH : S_FREEZE,
              4 + i, 3, "frz_hold");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_FLUSH, S_FREEZE, 9, 3, "frz_fl2");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_FLUSH, S_FLUSH,  9, 3, "frz_fl3");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   S_RUN,    9, 3, "frz_done");

      // stall counter saturates at 15
      for (int i = 0; i < 20; i++)
         step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, C_ZERO, (i == 0) ? S_RUN : S_FREEZE,
              (9 + i > 15) ? 15 : 9 + i, 3, "sat");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   S_FREEZE, 15, 3, "sat_top");

      // clear wins over a same-cycle stall
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, C_STALL, S_RUN,    15, 3, "clr_stall");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   S_LSTALL, 0,  0, "clr_after");

      // reset mid load-stall and mid flush
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_STALL, S_RUN, 0, 0, "rst_lu_req");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_ZERO,  S_RUN, 0, 0, "rst_lu");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   S_RUN, 0, 0, "rst_lu_rel");
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_FLUSH, S_RUN, 0, 0, "rst_br");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_ZERO,  S_RUN, 0, 0, "rst_fl");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   S_RUN, 0, 0, "rst_fl_rel");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
